rv_fetch_icache: RTL

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory bus. On the fetch side it uses the same request protocol as the raw instruction memory: address accepted on ack, data one cycle later. It can therefore be inserted without changing the fetch stage. Misses trigger a sequential line refill from the memory bus; a flush input invalidates all lines (fence.i).

---
 rtl/rv_icache_pkg.sv | 22 ++
 rtl/rv_icache_data_ram.sv | 37 +++
 rtl/rv_fetch_icache.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rv_icache_pkg.sv
// Shared types and helpers for the direct-mapped fetch instruction cache.
package rv_icache_pkg;

  typedef enum logic {
    IDLE,
    REFILL
  } icache_state_t;

  localparam int unsigned DEFAULT_LINE_WORDS_BITS = 2;
  localparam int unsigned LINE_WORDS = 1 << DEFAULT_LINE_WORDS_BITS;

  function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                           input int unsigned line_words_bits,
                                           input int unsigned index_bits);
    return addr_bits - 2 - line_words_bits - index_bits;
  endfunction

  function automatic int unsigned line_words(input int unsigned line_words_bits);
    return 1 << line_words_bits;
  endfunction

endpackage

// File: rtl/rv_icache_data_ram.sv
// Instruction cache data array: one write port, one read port with a registered output.
module rv_icache_data_ram
  import rv_icache_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Output register holds the last read until the next read enable.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= mem_q[i_raddr];
    end
  end

endmodule

// File: rtl/rv_fetch_icache.sv
// Direct-mapped read-only instruction cache with sequential line refill and fence.i flush.
// Optional hit/miss statistics outputs are enabled by defining RV_ICACHE_STATS_EN.
module rv_fetch_icache
  import rv_icache_pkg::*;
#(
  parameter int unsigned IADDR_SPACE_BITS = 16,
  parameter int unsigned LINE_WORDS_BITS  = DEFAULT_LINE_WORDS_BITS,
  parameter int unsigned INDEX_BITS       = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [IADDR_SPACE_BITS-1:0] i_addr,
  input  logic                        i_cyc,
  output logic                        o_ack,
  output logic [31:0]                 o_instruction,
  input  logic                        i_invalidate,
  output logic [IADDR_SPACE_BITS-1:0] o_mem_addr,
  output logic                        o_mem_cyc,
  input  logic                        i_mem_ack,
  input  logic [31:0]                 i_mem_data
`ifdef RV_ICACHE_STATS_EN
  ,
  output logic [31:0]                 o_hit_count,
  output logic [31:0]                 o_miss_count
`endif
);

  localparam int unsigned TAG_BITS      = tag_bits(IADDR_SPACE_BITS, LINE_WORDS_BITS, INDEX_BITS);
  localparam int unsigned NUM_LINES     = 1 << INDEX_BITS;
  localparam int unsigned LWORDS        = line_words(LINE_WORDS_BITS);
  localparam int unsigned CNT_BITS      = LINE_WORDS_BITS + 1;
  localparam int unsigned LINE_BITS     = TAG_BITS + INDEX_BITS;
  localparam int unsigned RAM_ADDR_BITS = INDEX_BITS + LINE_WORDS_BITS;

  icache_state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q [NUM_LINES];
  logic [LINE_BITS-1:0] line_base_q;
  logic [CNT_BITS-1:0]  issue_cnt_q;
  logic [CNT_BITS-1:0]  ret_cnt_q;
  logic                 ret_pend_q;
  logic                 discard_q;

  logic [LINE_WORDS_BITS-1:0] req_off;
  logic [INDEX_BITS-1:0]      req_idx;
  logic [TAG_BITS-1:0]        req_tag;
  logic [INDEX_BITS-1:0]      fill_idx;
  logic [TAG_BITS-1:0]        fill_tag;
  logic                       lookup_hit;
  logic                       hit;
  logic                       miss;
  logic                       mem_cyc;
  logic                       fill_done;
  logic                       unused_addr_bits;

  assign req_off  = i_addr[2 +: LINE_WORDS_BITS];
  assign req_idx  = i_addr[2 + LINE_WORDS_BITS +: INDEX_BITS];
  assign req_tag  = i_addr[IADDR_SPACE_BITS-1 -: TAG_BITS];
  assign fill_idx = line_base_q[INDEX_BITS-1:0];
  assign fill_tag = line_base_q[LINE_BITS-1 -: TAG_BITS];

  assign unused_addr_bits = ^i_addr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    hit       = 1'b0;
    miss      = 1'b0;
    mem_cyc   = 1'b0;
    fill_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_cyc) begin
          if (lookup_hit) begin
            hit = 1'b1;
          end else begin
            miss    = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        // Issue counter MSB set means every word of the line has been requested.
        mem_cyc = ~issue_cnt_q[CNT_BITS-1];
        if (ret_pend_q && (ret_cnt_q == CNT_BITS'(LWORDS - 1))) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (miss) begin
      valid_d[req_idx] = 1'b0;
    end
    if (fill_done && !discard_q && !i_invalidate) begin
      valid_d[fill_idx] = 1'b1;
    end
    if (i_invalidate) begin
      valid_d = '0;
    end
  end

  assign o_ack      = hit;
  assign o_mem_cyc  = mem_cyc;
  assign o_mem_addr = mem_cyc ? {line_base_q, issue_cnt_q[LINE_WORDS_BITS-1:0], 2'b00} : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      line_base_q <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      ret_pend_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ret_pend_q <= mem_cyc & i_mem_ack;
      if (miss) begin
        line_base_q <= {req_tag, req_idx};
        issue_cnt_q <= '0;
        ret_cnt_q   <= '0;
      end else begin
        if (mem_cyc && i_mem_ack) begin
          issue_cnt_q <= issue_cnt_q + 1'b1;
        end
        if (ret_pend_q) begin
          ret_cnt_q <= ret_cnt_q + 1'b1;
        end
      end
      if (state_q == REFILL) begin
        if (fill_done) begin
          discard_q <= 1'b0;
        end else if (i_invalidate) begin
          discard_q <= 1'b1;
        end
      end
    end
  end

  // Tag array is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge i_clk) begin
    if (fill_done) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  rv_icache_data_ram #(
    .ADDR_BITS(RAM_ADDR_BITS),
    .DATA_BITS(32)
  ) u_data_ram (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_we     (ret_pend_q),
    .i_waddr  ({fill_idx, ret_cnt_q[LINE_WORDS_BITS-1:0]}),
    .i_wdata  (i_mem_data),
    .i_re     (hit),
    .i_raddr  ({req_idx, req_off}),
    .o_rdata  (o_instruction)
  );

`ifdef RV_ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign o_hit_count  = hit_count_q;
  assign o_miss_count = miss_count_q;
`endif

endmodule
